// File: rtl/cdb_broadcaster_pkg.sv
// Shared machine definitions for the common data bus: ROB sizing, datapath width
// and the broadcast packet seen by RS entries, the map table and the ROB.
package cdb_broadcaster_pkg;

  localparam int ROB_LEN    = 32;
  localparam int XLEN       = 32;
  localparam int NUM_FU_DEF = 4;
  localparam int ROB_TAG_W  = $clog2(ROB_LEN);

  // Tag 0 is reserved: an idle bus always carries reg_tag == 0.
  typedef struct packed {
    logic [ROB_TAG_W-1:0] reg_tag;
    logic [XLEN-1:0]      reg_value;
  } CDB_PACKET;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping
// modulo N. Also shared with the issue-select logic.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [N-1:0]  grant_s;
  logic [IW-1:0] grant_idx_s;
  logic          any_grant_s;

  // Rotating priority search; the first hit blocks all later candidates.
  always_comb begin
    int idx;
    grant_s     = '0;
    grant_idx_s = '0;
    any_grant_s = 1'b0;
    idx         = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any_grant_s && req[idx]) begin
        grant_s[idx] = 1'b1;
        grant_idx_s  = IW'(idx);
        any_grant_s  = 1'b1;
      end else begin
        any_grant_s = any_grant_s;
      end
    end
  end

  assign grant     = grant_s;
  assign grant_idx = grant_idx_s;
  assign any_grant = any_grant_s;

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: one-deep result slot per FU, round-robin pick of one slot per
// cycle, and a registered broadcast packet. Occupied, ungranted slots back-pressure.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int TAG_W  = ROB_TAG_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*XLEN-1:0]   fu_value,
  output logic [NUM_FU-1:0]        fu_ready,
  output CDB_PACKET                cdb_packet_out,
  output logic                     cdb_valid
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] slot_valid_r;
  logic [TAG_W-1:0]  slot_tag_r   [NUM_FU];
  logic [XLEN-1:0]   slot_value_r [NUM_FU];
  logic [PW-1:0]     rr_ptr_r;
  logic [PW-1:0]     rr_ptr_next_s;
  logic [PW-1:0]     grant_idx_s;
  logic [NUM_FU-1:0] grant_s;
  logic              any_grant_s;
  CDB_PACKET         cdb_packet_r;
  logic              cdb_valid_r;

  rr_arbiter #(.N(NUM_FU), .IW(PW)) u_arb (
    .req       (slot_valid_r),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (any_grant_s)
  );

  // A granted slot drains this edge, so it can take a new result at the same time.
  assign fu_ready = ~slot_valid_r | grant_s;

  // Pointer advances past the winner so it has lowest priority next time.
  always_comb begin
    rr_ptr_next_s = rr_ptr_r;
    if (any_grant_s) begin
      if (grant_idx_s == PW'(NUM_FU - 1)) begin
        rr_ptr_next_s = '0;
      end else begin
        rr_ptr_next_s = grant_idx_s + PW'(1);
      end
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
  end

  // Slot capture / drain and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      slot_valid_r <= '0;
      rr_ptr_r     <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_tag_r[i]   <= '0;
        slot_value_r[i] <= '0;
      end
    end else begin
      rr_ptr_r <= rr_ptr_next_s;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          slot_valid_r[i] <= 1'b1;
          slot_tag_r[i]   <= fu_tag[i*TAG_W +: TAG_W];
          slot_value_r[i] <= fu_value[i*XLEN +: XLEN];
        end else if (grant_s[i]) begin
          slot_valid_r[i] <= 1'b0;
        end else begin
          slot_valid_r[i] <= slot_valid_r[i];
        end
      end
    end
  end

  // Broadcast register; an idle or flushed bus carries an all-zero packet.
  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      cdb_valid_r  <= 1'b0;
      cdb_packet_r <= '0;
    end else if (any_grant_s) begin
      cdb_valid_r            <= 1'b1;
      cdb_packet_r.reg_tag   <= slot_tag_r[grant_idx_s];
      cdb_packet_r.reg_value <= slot_value_r[grant_idx_s];
    end else begin
      cdb_valid_r  <= 1'b0;
      cdb_packet_r <= '0;
    end
  end

  assign cdb_packet_out = cdb_packet_r;
  assign cdb_valid      = cdb_valid_r;

endmodule
